// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the reduced RISC-V core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB, handshakes with instruction and
// data memories, drives datapath enables/muxes, counts retired
// instructions and halts on an illegal opcode or a memory timeout.
module multicycle_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  output logic                  imem_req,
  input  logic                  imem_valid,
  output logic                  dmem_req,
  output logic                  dmem_we,
  input  logic                  dmem_ready,
  input  logic                  EQ,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  PCsrc,
  output logic                  RegWrite,
  output logic                  ALUsrc,
  output logic [1:0]            ImmSrc,
  output logic [2:0]            ALUctrl,
  output logic                  ResultSrc,
  output logic                  halt,
  output logic                  err,
  output logic [2:0]            state_out,
  output logic [CNT_WIDTH-1:0]  instret
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BNE  = 7'b1100011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;

  // Counter only needs to reach WAIT_LIMIT-1: expiry fires on the cycle the
  // count of waiting cycles would hit WAIT_LIMIT.
  localparam int WCW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WCW-1:0] LIM_M1 = WCW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  state_t           state, next_state;
  logic [6:0]       opcode;
  logic [WCW-1:0]   wait_cnt;
  logic             waiting;
  logic             expired;
  logic             retire;

  // Only the opcode field of the instruction is decoded here.
  logic instr_unused;
  assign instr_unused = ^instr[DATA_WIDTH-1:7];

  assign state_out = state;

  // Next-state and per-state control outputs; everything idles during reset.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCsrc      = 1'b0;
    RegWrite   = 1'b0;
    ALUsrc     = 1'b0;
    ImmSrc     = 2'b00;
    ALUctrl    = 3'b000;
    ResultSrc  = 1'b0;
    halt       = 1'b0;
    waiting    = 1'b0;
    retire     = 1'b0;
    expired    = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_valid) begin
            IRWrite    = 1'b1;
            next_state = S_DECODE;
          end else begin
            waiting = 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_ADDI, OP_BNE, OP_LW, OP_SW: next_state = S_EXECUTE;
            default:                       next_state = S_HALT;
          endcase
        end
        S_EXECUTE: begin
          case (opcode)
            OP_ADDI: begin
              ALUsrc     = 1'b1;
              ImmSrc     = 2'b01;
              next_state = S_WB;
            end
            OP_BNE: begin
              ImmSrc     = 2'b11;
              ALUctrl    = 3'b001;
              PCWrite    = 1'b1;
              PCsrc      = ~EQ;
              retire     = 1'b1;
              next_state = S_FETCH;
            end
            OP_LW: begin
              ALUsrc     = 1'b1;
              ImmSrc     = 2'b01;
              next_state = S_MEM;
            end
            OP_SW: begin
              ALUsrc     = 1'b1;
              ImmSrc     = 2'b10;
              next_state = S_MEM;
            end
            default: next_state = S_HALT;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          ALUsrc   = 1'b1;
          if (opcode == OP_SW) begin
            dmem_we = 1'b1;
            ImmSrc  = 2'b10;
          end else begin
            ImmSrc  = 2'b01;
          end
          if (dmem_ready) begin
            if (opcode == OP_SW) begin
              PCWrite    = 1'b1;
              retire     = 1'b1;
              next_state = S_FETCH;
            end else begin
              next_state = S_WB;
            end
          end else begin
            waiting = 1'b1;
          end
        end
        S_WB: begin
          RegWrite   = 1'b1;
          ResultSrc  = (opcode == OP_LW);
          PCWrite    = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_HALT: halt = 1'b1;
        default: next_state = S_HALT;
      endcase
      // A handshake in the expiry cycle clears waiting, so it wins.
      if (waiting && (WAIT_LIMIT != 0) && (wait_cnt == LIM_M1)) begin
        expired    = 1'b1;
        next_state = S_HALT;
      end
    end
  end

  // State, latched opcode, wait counter, retire counter and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      opcode   <= 7'd0;
      wait_cnt <= '0;
      instret  <= '0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      if (IRWrite) opcode <= instr[6:0];
      if (next_state != state)
        wait_cnt <= '0;
      else if (waiting && (WAIT_LIMIT != 0))
        wait_cnt <= wait_cnt + 1'b1;
      if (retire) instret <= instret + CNT_WIDTH'(1);
      if (expired) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: each scenario queues
// per-cycle stimulus alongside the expected control vector, then replays.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        imem_req, imem_valid, dmem_req, dmem_we, dmem_ready, EQ;
  logic        IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc, ResultSrc, halt, err;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUctrl, state_out;
  logic [31:0] instret;

  multicycle_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(32), .WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_req(imem_req),
    .imem_valid(imem_valid), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .EQ(EQ), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ImmSrc(ImmSrc),
    .ALUctrl(ALUctrl), .ResultSrc(ResultSrc), .halt(halt), .err(err),
    .state_out(state_out), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, valid, ready, eq;
    logic [31:0] ins;
  } stim_t;

  typedef struct packed {
    logic [2:0] st;
    logic       imq, irw, pcw, pcs, rw, als;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       rs, dq, dw, h, er;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] exp_instret = 0;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_BNE  = 32'hFE209EE3;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  function automatic exp_t c(input logic [2:0] st, input logic imq, irw, pcw, pcs, rw, als,
                             input logic [1:0] imm, input logic [2:0] alu,
                             input logic rs, dq, dw, h, er);
    c = '{st, imq, irw, pcw, pcs, rw, als, imm, alu, rs, dq, dw, h, er};
  endfunction

  task automatic sp(input logic r, v, rd, q, input logic [31:0] ins, input exp_t e);
    stim_q.push_back('{r, v, rd, q, ins});
    exp_q.push_back(e);
  endtask

  // Replay queued stimulus one cycle at a time, comparing outputs mid-cycle.
  task automatic run_q(input string name);
    int cyc = 0;
    while (stim_q.size() > 0) begin
      stim_t s = stim_q.pop_front();
      exp_t  e = exp_q.pop_front();
      exp_t  got;
      rst_n = s.rst; imem_valid = s.valid; dmem_ready = s.ready; EQ = s.eq; instr = s.ins;
      #1;
      got = {state_out, imem_req, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc, ImmSrc,
             ALUctrl, ResultSrc, dmem_req, dmem_we, halt, err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s cyc %0d got %h exp %h", name, cyc, got, e);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_instret(input string name);
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL %s instret got %0d exp %0d", name, instret, exp_instret);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; imem_valid = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_valid = 1'b1; dmem_ready = 1'b1; EQ = 1'b0; instr = I_ADDI;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({state_out, err, instret} !== {3'd0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state got %h/%b/%0d exp 0/0/0", state_out, err, instret);
    end
    checks++;
    if ({imem_req, IRWrite, PCWrite, RegWrite, dmem_req, halt} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000",
               {imem_req, IRWrite, PCWrite, RegWrite, dmem_req, halt});
    end
    rst_n = 1'b1;
    exp_instret = 0;
  endtask

  task automatic test_addi();
    sp(1, 1, 1, 0, I_ADDI, c(0, 1,1,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 1, 0, I_ADDI, c(1, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 1, 0, I_ADDI, c(2, 0,0,0,0,0,1, 2'b01, 3'b000, 0,0,0,0,0));
    sp(1, 1, 1, 0, I_ADDI, c(4, 0,0,1,0,1,0, 2'b00, 3'b000, 0,0,0,0,0));
    exp_instret++;
    run_q("addi");
    check_instret("addi");
  endtask

  task automatic test_bne(input logic eq);
    sp(1, 1, 1, eq, I_BNE, c(0, 1,1,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 1, eq, I_BNE, c(1, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 1, eq, I_BNE, c(2, 0,0,1,~eq,0,0, 2'b11, 3'b001, 0,0,0,0,0));
    exp_instret++;
    run_q(eq ? "bne_eq1" : "bne_eq0");
    check_instret("bne");
  endtask

  // lw with dmem_ready arriving on the 4th MEM cycle, which is also the
  // cycle the wait counter would expire: the handshake must win.
  task automatic test_lw_delayed();
    sp(1, 1, 0, 0, I_LW, c(0, 1,1,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 0, 0, I_LW, c(1, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 0, 0, I_LW, c(2, 0,0,0,0,0,1, 2'b01, 3'b000, 0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      sp(1, 1, (i == 3), 0, I_LW, c(3, 0,0,0,0,0,1, 2'b01, 3'b000, 0,1,0,0,0));
    sp(1, 1, 1, 0, I_LW, c(4, 0,0,1,0,1,0, 2'b00, 3'b000, 1,0,0,0,0));
    exp_instret++;
    run_q("lw_delayed");
    check_instret("lw");
  endtask

  task automatic test_sw();
    sp(1, 1, 1, 0, I_SW, c(0, 1,1,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 1, 0, I_SW, c(1, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 1, 0, I_SW, c(2, 0,0,0,0,0,1, 2'b10, 3'b000, 0,0,0,0,0));
    sp(1, 1, 1, 0, I_SW, c(3, 0,0,1,0,0,1, 2'b10, 3'b000, 0,1,1,0,0));
    sp(1, 0, 0, 0, I_SW, c(0, 1,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    exp_instret++;
    run_q("sw");
    check_instret("sw");
  endtask

  task automatic test_illegal();
    sp(1, 1, 1, 0, I_ILL, c(0, 1,1,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 0, 1, 0, I_ILL, c(1, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      sp(1, i[0], 1, 0, I_ADDI, c(5, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,1,0));
    run_q("illegal");
    check_instret("illegal");
  endtask

  task automatic test_fetch_timeout();
    for (int i = 0; i < 4; i++)
      sp(1, 0, 0, 0, I_ADDI, c(0, 1,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 1, 0, I_ADDI, c(5, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,1,1));
    sp(1, 1, 1, 0, I_ADDI, c(5, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,1,1));
    run_q("fetch_timeout");
    check_instret("fetch_timeout");
  endtask

  task automatic test_mem_timeout();
    sp(1, 1, 0, 0, I_LW, c(0, 1,1,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 0, 0, I_LW, c(1, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 0, 0, I_LW, c(2, 0,0,0,0,0,1, 2'b01, 3'b000, 0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      sp(1, 1, 0, 0, I_LW, c(3, 0,0,0,0,0,1, 2'b01, 3'b000, 0,1,0,0,0));
    sp(1, 1, 1, 0, I_LW, c(5, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,1,1));
    run_q("mem_timeout");
    check_instret("mem_timeout");
  endtask

  // Retire one addi, then abandon a lw in MEM via reset: count returns to 0.
  task automatic test_reset_in_mem();
    test_addi();
    sp(1, 1, 0, 0, I_LW, c(0, 1,1,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 0, 0, I_LW, c(1, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 1, 0, 0, I_LW, c(2, 0,0,0,0,0,1, 2'b01, 3'b000, 0,0,0,0,0));
    sp(1, 1, 0, 0, I_LW, c(3, 0,0,0,0,0,1, 2'b01, 3'b000, 0,1,0,0,0));
    sp(0, 1, 1, 0, I_LW, c(3, 0,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    sp(1, 0, 0, 0, I_LW, c(0, 1,0,0,0,0,0, 2'b00, 3'b000, 0,0,0,0,0));
    exp_instret = 0;
    run_q("reset_in_mem");
    check_instret("reset_in_mem");
  endtask

  initial begin
    rst_n = 1'b0; imem_valid = 1'b0; dmem_ready = 1'b0; EQ = 1'b0; instr = '0;
    test_reset();
    test_addi();
    test_bne(1'b0);
    test_bne(1'b1);
    test_lw_delayed();
    test_sw();
    test_illegal();
    apply_reset();
    test_fetch_timeout();
    apply_reset();
    test_mem_timeout();
    apply_reset();
    test_reset_in_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
